// File: rtl/cpu_core.sv
// cpu_core: 32-bit multi-cycle core (FETCH -> DECODE -> EXECUTE) executing
// register-register ALU ops, LOADI and HALT over a shared memory bus.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   addr_bus        byte address, always the current PC
//   data_bus        memory data (sampled on fetch, never driven by the core)
//   mem_read        read request, high only in FETCH
//   mem_write       write request, tied 0
//   mem_ready       memory data valid this cycle
//   interrupt_req   ignored; interrupt_ack tied 0
//   io_addr/io_read/io_write tied 0; io_data left high-Z
//   halted          core stopped on HALT
//   user_mode       tied 0 (kernel mode)

// Register file: two combinational read ports, one synchronous write port.
module cpu_reg_file #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        rd_addr_a_i,
  input  logic [4:0]        rd_addr_b_i,
  output logic [DATA_W-1:0] rd_data_a_o,
  output logic [DATA_W-1:0] rd_data_b_o,
  input  logic              wr_en_i,
  input  logic [4:0]        wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i
);

  logic [DATA_W-1:0] registers [0:NUM_REGS-1];

  // R0 is never written, so it holds its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        registers[i] <= '0;
      end
    end else if (wr_en_i && (wr_addr_i != 5'd0)) begin
      registers[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_a_o = (rd_addr_a_i == 5'd0) ? '0 : registers[rd_addr_a_i];
  assign rd_data_b_o = (rd_addr_b_i == 5'd0) ? '0 : registers[rd_addr_b_i];

endmodule

module cpu_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_8000,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] addr_bus,
  inout  logic [31:0] data_bus,
  output logic        mem_read,
  output logic        mem_write,
  input  logic        mem_ready,
  input  logic [7:0]  interrupt_req,
  output logic        interrupt_ack,
  output logic [7:0]  io_addr,
  inout  logic [7:0]  io_data,
  output logic        io_read,
  output logic        io_write,
  output logic        halted,
  output logic        user_mode
);

  localparam int unsigned XLEN = 32;

  localparam logic [5:0] OP_ADD   = 6'h00;
  localparam logic [5:0] OP_SUB   = 6'h01;
  localparam logic [5:0] OP_AND   = 6'h02;
  localparam logic [5:0] OP_OR    = 6'h03;
  localparam logic [5:0] OP_XOR   = 6'h04;
  localparam logic [5:0] OP_NOT   = 6'h05;
  localparam logic [5:0] OP_SHL   = 6'h06;
  localparam logic [5:0] OP_SHR   = 6'h07;
  localparam logic [5:0] OP_MUL   = 6'h08;
  localparam logic [5:0] OP_DIV   = 6'h09;
  localparam logic [5:0] OP_MOD   = 6'h0A;
  localparam logic [5:0] OP_CMP   = 6'h0B;
  localparam logic [5:0] OP_SAR   = 6'h0C;
  localparam logic [5:0] OP_LOADI = 6'h12;
  localparam logic [5:0] OP_HALT  = 6'h3E;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_HALT
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   ir_q, ir_d;
  logic [XLEN-1:0]   op_a_q, op_a_d;
  logic [XLEN-1:0]   op_b_q, op_b_d;
  logic [3:0]        flags_q, flags_d;     // {Z, N, C, V}
  logic              mem_read_q, mem_read_d;
  logic              halted_q, halted_d;

  logic [5:0]        opcode;
  logic [4:0]        rd_idx, rs1_idx, rs2_idx;
  logic [13:0]       imm14;
  logic [XLEN-1:0]   rf_a_c, rf_b_c;
  logic              rf_we_c;

  logic [XLEN:0]     sum_c, diff_c;
  logic [XLEN-1:0]   alu_res_c;
  logic              alu_wr_c, alu_flags_c, alu_carry_c, alu_ovf_c;

  assign opcode  = ir_q[31:26];
  assign rd_idx  = ir_q[23:19];
  assign rs1_idx = ir_q[18:14];
  assign rs2_idx = ir_q[13:9];
  assign imm14   = ir_q[13:0];

  cpu_reg_file #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (XLEN)
  ) reg_file_inst (
    .clk         (clk),
    .rst         (rst),
    .rd_addr_a_i (rs1_idx),
    .rd_addr_b_i (rs2_idx),
    .rd_data_a_o (rf_a_c),
    .rd_data_b_o (rf_b_c),
    .wr_en_i     (rf_we_c),
    .wr_addr_i   (rd_idx),
    .wr_data_i   (alu_res_c)
  );

  // SUB/CMP carry is the not-borrow: a + ~b + 1.
  assign sum_c  = {1'b0, op_a_q} + {1'b0, op_b_q};
  assign diff_c = {1'b0, op_a_q} + {1'b0, ~op_b_q} + 33'd1;

  // ALU result, write enable and flag-update decision for the latched opcode.
  always_comb begin
    alu_res_c   = '0;
    alu_wr_c    = 1'b0;
    alu_flags_c = 1'b0;
    alu_carry_c = 1'b0;
    alu_ovf_c   = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_res_c   = sum_c[XLEN-1:0];
        alu_carry_c = sum_c[XLEN];
        alu_ovf_c   = (op_a_q[31] == op_b_q[31]) && (sum_c[31] != op_a_q[31]);
        alu_wr_c    = 1'b1;
        alu_flags_c = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        alu_res_c   = diff_c[XLEN-1:0];
        alu_carry_c = diff_c[XLEN];
        alu_ovf_c   = (op_a_q[31] != op_b_q[31]) && (diff_c[31] != op_a_q[31]);
        alu_wr_c    = (opcode == OP_SUB);
        alu_flags_c = 1'b1;
      end
      OP_AND: begin alu_res_c = op_a_q & op_b_q; alu_wr_c = 1'b1; alu_flags_c = 1'b1; end
      OP_OR:  begin alu_res_c = op_a_q | op_b_q; alu_wr_c = 1'b1; alu_flags_c = 1'b1; end
      OP_XOR: begin alu_res_c = op_a_q ^ op_b_q; alu_wr_c = 1'b1; alu_flags_c = 1'b1; end
      OP_NOT: begin alu_res_c = ~op_a_q;         alu_wr_c = 1'b1; alu_flags_c = 1'b1; end
      OP_SHL: begin
        alu_res_c = op_a_q << op_b_q[4:0]; alu_wr_c = 1'b1; alu_flags_c = 1'b1;
      end
      OP_SHR: begin
        alu_res_c = op_a_q >> op_b_q[4:0]; alu_wr_c = 1'b1; alu_flags_c = 1'b1;
      end
      OP_SAR: begin
        alu_res_c = XLEN'($signed(op_a_q) >>> op_b_q[4:0]); alu_wr_c = 1'b1; alu_flags_c = 1'b1;
      end
      OP_MUL: begin
        alu_res_c = op_a_q * op_b_q; alu_wr_c = 1'b1; alu_flags_c = 1'b1;
      end
      // Divide by zero: quotient saturates to all-ones, remainder is the dividend.
      OP_DIV: begin
        alu_res_c = (op_b_q == '0) ? '1 : (op_a_q / op_b_q); alu_wr_c = 1'b1; alu_flags_c = 1'b1;
      end
      OP_MOD: begin
        alu_res_c = (op_b_q == '0) ? op_a_q : (op_a_q % op_b_q); alu_wr_c = 1'b1; alu_flags_c = 1'b1;
      end
      OP_LOADI: begin
        alu_res_c = XLEN'(imm14); alu_wr_c = 1'b1;
      end
      default: ;
    endcase
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    flags_d = flags_q;
    rf_we_c = 1'b0;
    case (state_q)
      // The request must be visible on the bus before data is accepted.
      ST_FETCH: begin
        if (mem_read_q && mem_ready) begin
          ir_d    = data_bus;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        op_a_d  = rf_a_c;
        op_b_d  = rf_b_c;
        state_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        if (opcode == OP_HALT) begin
          state_d = ST_HALT;
        end else begin
          rf_we_c = alu_wr_c;
          if (alu_flags_c) begin
            flags_d = {(alu_res_c == '0), alu_res_c[31], alu_carry_c, alu_ovf_c};
          end
          pc_d    = pc_q + 32'd4;
          state_d = ST_FETCH;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
    mem_read_d = (state_d == ST_FETCH);
    halted_d   = (state_d == ST_HALT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      flags_q    <= '0;
      mem_read_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      flags_q    <= flags_d;
      mem_read_q <= mem_read_d;
      halted_q   <= halted_d;
    end
  end

  assign addr_bus      = pc_q;
  assign mem_read      = mem_read_q;
  assign halted        = halted_q;
  assign data_bus      = 'z;
  assign mem_write     = 1'b0;
  assign interrupt_ack = 1'b0;
  assign io_addr       = '0;
  assign io_data       = 'z;
  assign io_read       = 1'b0;
  assign io_write      = 1'b0;
  assign user_mode     = 1'b0;

  // Inputs reserved for later revisions.
  logic unused_ok;
  assign unused_ok = ^{interrupt_req, io_data, ir_q[25:24]};

endmodule

// File: tb/tb_cpu_core.sv
module tb_cpu_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr_bus;
  wire  [31:0] data_bus;
  logic        mem_read, mem_write;
  logic        mem_ready = 1'b1;
  logic [7:0]  interrupt_req = 8'hFF;
  logic        interrupt_ack;
  logic [7:0]  io_addr;
  wire  [7:0]  io_data;
  logic        io_read, io_write, halted, user_mode;

  cpu_core dut (
    .clk           (clk),
    .rst           (rst),
    .addr_bus      (addr_bus),
    .data_bus      (data_bus),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_ready     (mem_ready),
    .interrupt_req (interrupt_req),
    .interrupt_ack (interrupt_ack),
    .io_addr       (io_addr),
    .io_data       (io_data),
    .io_read       (io_read),
    .io_write      (io_write),
    .halted        (halted),
    .user_mode     (user_mode)
  );

  always #5ns clk = ~clk;

  // Program memory: 64 words starting at byte 0x8000.
  logic [31:0] mem [0:63];
  logic [31:0] mem_word;
  assign mem_word = mem[addr_bus[7:2]];
  assign data_bus = mem_read ? mem_word : 32'hzzzz_zzzz;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Scoreboards: expected fetch addresses and final register contents.
  typedef struct {
    int unsigned idx;
    logic [31:0] val;
  } reg_exp_t;
  logic [31:0] fetch_q [$];
  reg_exp_t    reg_q   [$];

  function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
    return {op, 2'b00, rd, rs1, rs2, 9'd0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [4:0] rd, input logic [13:0] imm);
    return {6'h12, 2'b00, rd, 5'd0, imm};
  endfunction

  task automatic push_fetches(input int n);
    for (int i = 0; i < n; i++) fetch_q.push_back(32'h8000 + 32'(4 * i));
  endtask

  task automatic push_reg(input int unsigned idx, input logic [31:0] val);
    reg_exp_t e;
    e.idx = idx;
    e.val = val;
    reg_q.push_back(e);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
  endtask

  task automatic load_arith();
    clear_mem();
    mem[0]  = enc_i(5'd1, 14'd5);
    mem[1]  = enc_i(5'd2, 14'd3);
    mem[2]  = enc_r(6'h00, 5'd3,  5'd1, 5'd2);
    mem[3]  = enc_r(6'h01, 5'd4,  5'd1, 5'd2);
    mem[4]  = enc_r(6'h02, 5'd5,  5'd1, 5'd2);
    mem[5]  = enc_r(6'h03, 5'd6,  5'd1, 5'd2);
    mem[6]  = enc_r(6'h04, 5'd7,  5'd1, 5'd2);
    mem[7]  = enc_r(6'h05, 5'd8,  5'd1, 5'd0);
    mem[8]  = enc_r(6'h06, 5'd9,  5'd1, 5'd2);
    mem[9]  = enc_r(6'h07, 5'd10, 5'd1, 5'd2);
    mem[10] = enc_r(6'h0C, 5'd11, 5'd1, 5'd2);
    mem[11] = enc_r(6'h08, 5'd12, 5'd1, 5'd2);
    mem[12] = enc_r(6'h09, 5'd13, 5'd1, 5'd2);
    mem[13] = enc_r(6'h0A, 5'd14, 5'd1, 5'd2);
    mem[14] = enc_r(6'h0B, 5'd15, 5'd1, 5'd2);
    mem[15] = enc_r(6'h3E, 5'd0,  5'd0, 5'd0);
  endtask

  task automatic exp_arith();
    push_fetches(16);
    push_reg(1, 32'd5);   push_reg(2, 32'd3);   push_reg(3, 32'd8);
    push_reg(4, 32'd2);   push_reg(5, 32'd1);   push_reg(6, 32'd7);
    push_reg(7, 32'd6);   push_reg(8, 32'hFFFF_FFFA);
    push_reg(9, 32'd40);  push_reg(10, 32'd0);  push_reg(11, 32'd0);
    push_reg(12, 32'd15); push_reg(13, 32'd1);  push_reg(14, 32'd2);
    push_reg(15, 32'd0);
  endtask

  // Divide by zero, SAR sign fill, R0 protection and an undefined opcode.
  task automatic load_edge();
    clear_mem();
    mem[0]  = enc_i(5'd1, 14'd7);
    mem[1]  = enc_i(5'd3, 14'd1);
    mem[2]  = enc_i(5'd4, 14'd31);
    mem[3]  = enc_r(6'h06, 5'd5,  5'd3, 5'd4);
    mem[4]  = enc_i(5'd6, 14'd4);
    mem[5]  = enc_r(6'h0C, 5'd7,  5'd5, 5'd6);
    mem[6]  = enc_r(6'h09, 5'd8,  5'd1, 5'd0);
    mem[7]  = enc_r(6'h0A, 5'd9,  5'd1, 5'd0);
    mem[8]  = enc_r(6'h00, 5'd0,  5'd1, 5'd3);
    mem[9]  = enc_r(6'h00, 5'd10, 5'd0, 5'd1);
    mem[10] = enc_r(6'h20, 5'd11, 5'd1, 5'd1);
    mem[11] = enc_r(6'h3E, 5'd0,  5'd0, 5'd0);
  endtask

  task automatic exp_edge();
    push_fetches(12);
    push_reg(5, 32'h8000_0000); push_reg(7, 32'hF800_0000);
    push_reg(8, 32'hFFFF_FFFF); push_reg(9, 32'd7);
    push_reg(0, 32'd0);         push_reg(10, 32'd7);
    push_reg(11, 32'd0);
  endtask

  // Fetch monitor: address order and spacing between accepted fetches.
  int cyc = 0;
  int prev_cyc = 0;
  int stall_cnt = 0;
  bit have_prev = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      have_prev = 1'b0;
      stall_cnt = 0;
    end else if (mem_read) begin
      if (!mem_ready) begin
        stall_cnt++;
      end else begin
        if (fetch_q.size() == 0) begin
          check_eq("fetch_extra", addr_bus, 32'hFFFF_FFFF);
        end else begin
          check_eq("fetch_addr", addr_bus, fetch_q.pop_front());
        end
        if (have_prev) check_eq("fetch_gap", 32'(cyc - prev_cyc), 32'(3 + stall_cnt));
        prev_cyc  = cyc;
        have_prev = 1'b1;
        stall_cnt = 0;
      end
    end
  end

  task automatic check_regs_zero(input string tag);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < 32; i++) acc |= dut.reg_file_inst.registers[i];
    check_eq(tag, acc, 32'h0);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #20ns;
    check_eq("rst_addr", addr_bus, 32'h8000);
    check_eq("rst_mem_read", 32'(mem_read), 32'd0);
    check_eq("rst_halted", 32'(halted), 32'd0);
    check_eq("rst_const_outs", {24'd0, io_addr} | 32'({mem_write, interrupt_ack, io_read, io_write, user_mode}), 32'd0);
    check_regs_zero("rst_regs");
    @(posedge clk);
    #1ns;
    rst = 1'b0;
  endtask

  task automatic wait_fetch();
    int k;
    k = 0;
    while (!mem_read && k < 20) begin
      @(posedge clk);
      #1ns;
      k++;
    end
    check_eq("fetch_seen", 32'(mem_read), 32'd1);
  endtask

  task automatic run_to_halt(input int budget);
    int k;
    k = 0;
    while (!halted && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_eq("halt_reached", 32'(halted), 32'd1);
  endtask

  task automatic check_final(input logic [31:0] exp_pc);
    reg_exp_t e;
    check_eq("halt_pc", addr_bus, exp_pc);
    check_eq("halt_mem_read", 32'(mem_read), 32'd0);
    check_eq("fetch_left", 32'(fetch_q.size()), 32'd0);
    while (reg_q.size() > 0) begin
      e = reg_q.pop_front();
      check_eq($sformatf("R%0d", e.idx), dut.reg_file_inst.registers[e.idx], e.val);
    end
  endtask

  initial begin
    // Run 1: full ALU program, no stall.
    load_arith();
    exp_arith();
    apply_reset();
    run_to_halt(300);
    check_final(32'h803C);
    check_eq("flags_cmp", 32'(dut.flags_q), 32'b0010);
    repeat (5) @(posedge clk);
    #1ns;
    check_eq("halt_sticky", 32'(halted), 32'd1);
    check_eq("halt_pc_sticky", addr_bus, 32'h803C);

    // Run 2: same program with a 4-cycle fetch stall; same results.
    load_arith();
    exp_arith();
    apply_reset();
    repeat (8) @(posedge clk);
    #1ns;
    wait_fetch();
    mem_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1ns;
    mem_ready = 1'b1;
    run_to_halt(300);
    check_final(32'h803C);

    // Run 3: edge cases.
    load_edge();
    exp_edge();
    apply_reset();
    run_to_halt(300);
    check_final(32'h802C);

    // Run 4: reset asserted while the second LOADI is in EXECUTE.
    clear_mem();
    mem[0] = enc_i(5'd1, 14'h155);
    mem[1] = enc_i(5'd2, 14'h2AA);
    mem[2] = enc_r(6'h3E, 5'd0, 5'd0, 5'd0);
    push_fetches(2);
    apply_reset();
    wait_fetch();
    @(posedge clk);
    #1ns;
    wait_fetch();
    @(posedge clk);
    @(posedge clk);
    #1ns;
    rst = 1'b1;
    #2ns;
    check_regs_zero("mid_exec_regs");
    check_eq("mid_exec_addr", addr_bus, 32'h8000);
    check_eq("mid_exec_mem_read", 32'(mem_read), 32'd0);
    @(posedge clk);
    #1ns;
    check_regs_zero("mid_exec_no_commit");
    push_fetches(3);
    push_reg(1, 32'h155);
    push_reg(2, 32'h2AA);
    rst = 1'b0;
    run_to_halt(100);
    check_final(32'h8008);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
